ser2par: RTL and testbench
==========================

# ser2par

Serial-to-parallel dibit assembler for the DQPSK modem receive path: the receive-side counterpart of `Par2Ser`. It collects bits from the serial stream at the bit clock and emits 2-bit symbols `{first bit, second bit}`, matching `Par2Ser` MSB-first ordering. It feeds the symbol mapper and demodulator chain. An optional sync-word hunter locks dibit phase before any symbols are released.

## Interface
- `SYNC_LEN`, default 8: sync word length in bits (2..16).
- `SYNC_WORD`, default 8'b1100_1100: pattern that establishes dibit phase; the last bit received is the LSB.
- `GAP_MAX`, default 16: consecutive idle cycles (`ser_valid`=0) in LOCKED that cause loss of lock.
- `clk_in  in  1`: bit clock, rising edge (200 kHz nominal).
- `rstn  in  1`: reset; synchronous and active-low.
- `data_ser  in  1`: serial data bit.
- `ser_valid  in  1`: `data_ser` is a valid bit this cycle.
- `align  in  1`: synchronous restart of dibit phase.
- `data_par  out  2`: assembled symbol; `[1]` is the first-received bit.
- `par_valid  out  1`: one-cycle pulse when `data_par` updates.
- `locked  out  1`: the phase is established and symbols are being released.

## Operation
- Reset (`rstn`=0 at an edge) sets: `data_par`=2'b00, `par_valid`=0, phase=0, state=HUNT, shift register=0, gap counter=0. `locked`=0 with sync enabled, and constant 1 without it.
- The phase bit selects where the next valid bit goes:
  - phase 0: the bit is stored as the MSB and phase toggles to 1.
  - phase 1: the pair is released and phase returns to 0.
- Cycles with `ser_valid`=0 hold the phase and any stored partial bit. `par_valid`=0 in those cycles.
- When `align`=1:
  - phase is cleared to 0 and any partial MSB is discarded.
  - a same-cycle valid bit is discarded.
  - `align` has priority over all other events.
- With sync enabled, the state machine has two states:
  - HUNT: each valid bit shifts in as `sr <= {sr[SYNC_LEN-2:0], data_ser}`. No symbols are output. When the updated `sr` equals `SYNC_WORD`, the state moves to LOCKED, phase is set to 0 and `locked` becomes 1. The next valid bit is the MSB of the first symbol.
  - LOCKED: pairs are assembled as above. The gap counter counts consecutive `ser_valid`=0 cycles and clears on any valid bit. When the count reaches `GAP_MAX`, the state returns to HUNT: `locked`=0, `sr` cleared, partial pair dropped.
  - `align` in either state forces HUNT and clears `sr`.
- The sync word bits are never emitted as symbols.

## Timing
- Let edge k sample the MSB and a later edge m sample the LSB, both with `ser_valid`=1. At edge m, `data_par` is loaded with {MSB, LSB} and `par_valid` is set to 1. The outputs are visible for the cycle after m: latency is one edge after the LSB is sampled.
- `data_par` holds its value until the next release; `par_valid` is never high for two consecutive cycles.
- Sync match at edge m: `locked` is 1 after edge m. An LSB sampled at that same edge is not possible, because phase is reset at that edge.
- Loss of lock: `locked` falls at the edge on which the gap count reaches `GAP_MAX`.
- Reset applied mid-pair drops the partial bit. The first valid bit after reset is an MSB (without sync) or is shifted into `sr` (with sync).

## Configuration
- `SER2PAR_SYNC_EN` defined: the HUNT/LOCKED state machine, shift register and gap counter are built, and `locked` behaves as described above.
- `SER2PAR_SYNC_EN` undefined: the module is always in LOCKED, `locked` is tied to 1, and `SYNC_LEN`, `SYNC_WORD` and `GAP_MAX` are unused. Dibit phase starts at reset or `align`.

## Structure
- Shared package `dqpsk_pkg` holds:
  - the state enum `ser2par_state_t` {HUNT, LOCKED};
  - constant `DQPSK_SYNC_WORD_DEF` (8'b1100_1100);
  - constant `DQPSK_SYM_W` (2).
- One sub-module, `sync_detect`: shift register plus comparator, built only under `SER2PAR_SYNC_EN`. Inputs are bit, valid and clear; output is a one-cycle `hit`.

## Test plan
- No sync: after reset, drive the valid bit stream 1,0,1,0,1,1,0,1,1,0,0,0,1,1 → `data_par` = 10,10,11,01,10,00,11 with one `par_valid` pulse per pair, each one edge after the LSB.
- Idle gaps: bits 1, (3 idle cycles), 0 → a single release of 2'b10 after the second bit, and no pulse during the gap.
- Align: send 1, then `align`=1 together with `ser_valid`=1 and bit 0, then bits 0,1 → a single release of 2'b01; the stray MSB and the same-cycle bit are both discarded.
- Sync: send 0,1 then 1,1,0,0,1,1,0,0 then 1,1,0,1 → `locked` rises after the last sync bit, the outputs are 11 then 01, and nothing is released before the match.
- Loss of lock: while LOCKED, hold `ser_valid`=0 for 16 cycles → `locked`=0 at the 16th edge; following bits produce no `par_valid` until the sync word is seen again.
- Reset mid-pair: MSB 1, then `rstn`=0 for 1 cycle, then bits 0,1 → `data_par`=2'b01, and all outputs read 0 (and `locked` reads 0) during reset.

Source files
------------

// File: rtl/dqpsk_pkg.sv
// Shared DQPSK receive-path types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dqpsk_pkg;

    // Dibit assembler lock state.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } ser2par_state_t;

    // Default pattern that establishes dibit phase (last bit received is the LSB).
    localparam logic [7:0] DQPSK_SYNC_WORD_DEF = 8'b1100_1100;

    // Bits per DQPSK symbol.
    localparam int unsigned DQPSK_SYM_W = 2;

endpackage

// File: rtl/ser2par_if.sv
// Serial-in / dibit-out bundle of the ser2par assembler.
// Latency: n/a (wiring only).
// Backpressure: none; the serial side is qualified by ser_valid, the symbol side by par_valid.
// Signals: data_ser/ser_valid/align (toward assembler), data_par/par_valid/locked (from it).
// master = bit source / symbol consumer, slave = the assembler.
interface ser2par_if;
    import dqpsk_pkg::*;

    logic                   data_ser;
    logic                   ser_valid;
    logic                   align;
    logic [DQPSK_SYM_W-1:0] data_par;
    logic                   par_valid;
    logic                   locked;

    modport master (
        output data_ser, ser_valid, align,
        input  data_par, par_valid, locked
    );

    modport slave (
        input  data_ser, ser_valid, align,
        output data_par, par_valid, locked
    );
endinterface

// File: rtl/sync_detect.sv
// Sync-word hunter: shift register plus comparator (only built with SER2PAR_SYNC_EN).
// Latency: hit is combinational from the bit being shifted in (asserts at the matching edge).
// Backpressure: none; shifts only when valid=1, clear has priority.
// Ports: clk_in, rstn (sync, active-low), bit_in, valid, clear -> hit.
`ifdef SER2PAR_SYNC_EN
module sync_detect
    import dqpsk_pkg::*;
#(
    parameter int unsigned         SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DQPSK_SYNC_WORD_DEF)
) (
    input  logic clk_in,
    input  logic rstn,
    input  logic bit_in,
    input  logic valid,
    input  logic clear,
    output logic hit
);
    logic [SYNC_LEN-1:0] sr_q;
    logic [SYNC_LEN-1:0] sr_d;
    logic [SYNC_LEN-1:0] sr_shift;

    // The match is taken on the updated register so the lock lands on the
    // same edge as the last sync bit.
    always_comb begin
        sr_shift = {sr_q[SYNC_LEN-2:0], bit_in};
        sr_d     = sr_q;
        hit      = 1'b0;
        if (clear) begin
            sr_d = '0;
        end else if (valid) begin
            sr_d = sr_shift;
            hit  = (sr_shift == SYNC_WORD);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end
endmodule
`endif

// File: rtl/ser2par.sv
// Serial-to-parallel dibit assembler: {first bit, second bit} per symbol, optional sync hunt.
// Latency: symbol and par_valid pulse appear one edge after the LSB is sampled.
// Backpressure: none; ser_valid=0 holds phase/partial bit, align restarts phase.
// Ports: clk_in, rstn (sync, active-low), sif (ser2par_if.slave).
// Build option SER2PAR_SYNC_EN: adds HUNT/LOCKED machine, sync_detect and idle-gap loss of lock.
module ser2par
    import dqpsk_pkg::*;
#(
    parameter int unsigned         SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DQPSK_SYNC_WORD_DEF),
    parameter int unsigned         GAP_MAX   = 16
) (
    input  logic      clk_in,
    input  logic      rstn,
    ser2par_if.slave  sif
);
    logic                   phase_q, phase_d;
    logic                   msb_q, msb_d;
    logic [DQPSK_SYM_W-1:0] data_par_q, data_par_d;
    logic                   par_valid_q, par_valid_d;

    // pair_clr restarts dibit phase; pair_vld feeds a bit into the pair.
    logic pair_clr;
    logic pair_vld;

`ifdef SER2PAR_SYNC_EN
    localparam int unsigned GW = $clog2(GAP_MAX + 1);

    ser2par_state_t state_q, state_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           hit;
    logic           sr_clr;
    logic           hunt_vld;

    sync_detect #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clk_in (clk_in),
        .rstn   (rstn),
        .bit_in (sif.data_ser),
        .valid  (hunt_vld),
        .clear  (sr_clr),
        .hit    (hit)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        sr_clr   = 1'b0;
        hunt_vld = 1'b0;
        if (sif.align) begin
            state_d = HUNT;
            gap_d   = '0;
            sr_clr  = 1'b1;
        end else if (state_q == HUNT) begin
            hunt_vld = sif.ser_valid;
            if (hit) begin
                state_d = LOCKED;
                gap_d   = '0;
            end
        end else if (sif.ser_valid) begin
            gap_d = '0;
        end else if (gap_q == GW'(GAP_MAX - 1)) begin
            state_d = HUNT;
            gap_d   = '0;
            sr_clr  = 1'b1;
        end else begin
            gap_d = gap_q + GW'(1);
        end
    end

    // Any state change (lock, loss of lock, align) restarts the pair; loss of
    // lock only happens on idle cycles so no bit is lost there.
    assign pair_clr   = sif.align || (state_d != state_q);
    assign pair_vld   = sif.ser_valid && (state_q == LOCKED);
    assign sif.locked = (state_q == LOCKED);

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            state_q <= HUNT;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end
`else
    // Sync parameters are only meaningful with the hunter built.
    logic unused_cfg;
    assign unused_cfg = ^{SYNC_WORD, 32'(SYNC_LEN), 32'(GAP_MAX)};

    assign pair_clr   = sif.align;
    assign pair_vld   = sif.ser_valid;
    assign sif.locked = 1'b1;
`endif

    always_comb begin
        phase_d     = phase_q;
        msb_d       = msb_q;
        data_par_d  = data_par_q;
        par_valid_d = 1'b0;
        if (pair_clr) begin
            phase_d = 1'b0;
            msb_d   = 1'b0;
        end else if (pair_vld) begin
            if (!phase_q) begin
                msb_d   = sif.data_ser;
                phase_d = 1'b1;
            end else begin
                data_par_d  = {msb_q, sif.data_ser};
                par_valid_d = 1'b1;
                phase_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            phase_q     <= 1'b0;
            msb_q       <= 1'b0;
            data_par_q  <= '0;
            par_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            msb_q       <= msb_d;
            data_par_q  <= data_par_d;
            par_valid_q <= par_valid_d;
        end
    end

    assign sif.data_par  = data_par_q;
    assign sif.par_valid = par_valid_q;
endmodule

// File: tb/tb_ser2par.sv
// Self-checking bench for ser2par: directed scenarios plus randomized traffic vs. a queue model.
// Latency: model predicts outputs one edge after inputs are sampled.
// Backpressure: none exercised (design has none).
module tb_ser2par;
    import dqpsk_pkg::*;

    localparam int unsigned SYNC_LEN  = 8;
    localparam logic [7:0]  SYNC_WORD = 8'b1100_1100;
    localparam int unsigned GAP_MAX   = 16;

    logic clk_in = 1'b0;
    logic rstn   = 1'b0;

    ser2par_if sif ();

    ser2par #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD),
        .GAP_MAX   (GAP_MAX)
    ) dut (
        .clk_in (clk_in),
        .rstn   (rstn),
        .sif    (sif.slave)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: pending pair bits, recent hunt bits, idle run.
    int m_part[$];
    int m_hist[$];
    int m_idle;
    int m_dat;
    int m_pv;
    int m_lk;

    int rel_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

`ifdef SER2PAR_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    task automatic model_step(input bit r, input bit v, input bit b, input bit a);
        int val;
        m_pv = 0;
        if (!r) begin
            m_dat = 0;
            m_part.delete();
            m_hist.delete();
            m_idle = 0;
            m_lk   = SYNC_ON ? 0 : 1;
        end else if (a) begin
            m_part.delete();
            m_hist.delete();
            m_idle = 0;
            if (SYNC_ON) m_lk = 0;
        end else if (m_lk == 0) begin
            if (v) begin
                m_hist.push_back(int'(b));
                if (m_hist.size() > SYNC_LEN) void'(m_hist.pop_front());
                val = 0;
                foreach (m_hist[i]) val = val * 2 + m_hist[i];
                if (val == int'(SYNC_WORD)) begin
                    m_lk   = 1;
                    m_idle = 0;
                    m_part.delete();
                end
            end
        end else if (v) begin
            m_idle = 0;
            m_part.push_back(int'(b));
            if (m_part.size() == 2) begin
                m_dat = m_part[0] * 2 + m_part[1];
                m_pv  = 1;
                m_part.delete();
            end
        end else begin
            m_idle++;
            if (SYNC_ON && m_idle == GAP_MAX) begin
                m_lk   = 0;
                m_idle = 0;
                m_hist.delete();
                m_part.delete();
            end
        end
    endtask

    task automatic cyc(input bit r, input bit v, input bit b, input bit a);
        @(negedge clk_in);
        rstn          = r;
        sif.ser_valid = v;
        sif.data_ser  = b;
        sif.align     = a;
        @(posedge clk_in);
        #1;
        model_step(r, v, b, a);
    endtask

    task automatic send(input int bits[$]);
        foreach (bits[i]) cyc(1'b1, 1'b1, bits[i][0], 1'b0);
    endtask

    // Establishes lock when the hunter is built; nothing otherwise.
    task automatic lock_up();
        if (SYNC_ON) begin
            for (int i = SYNC_LEN - 1; i >= 0; i--) cyc(1'b1, 1'b1, SYNC_WORD[i], 1'b0);
        end
    endtask

    task automatic expect_rel(input string name, input int exp[$]);
        check({name, "_count"}, rel_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < rel_q.size()) check({name, "_sym"}, rel_q[i], exp[i]);
        end
        rel_q.delete();
    endtask

    // Single compare process against the model, every cycle.
    always @(negedge clk_in) begin
        if (chk_en) begin
            check("data_par", {30'd0, sif.data_par}, m_dat);
            check("par_valid", {31'd0, sif.par_valid}, m_pv);
            check("locked", {31'd0, sif.locked}, m_lk);
            if (sif.par_valid === 1'b1) rel_q.push_back(int'(sif.data_par));
        end
    end

    initial begin
        int p;
        sif.data_ser  = 1'b0;
        sif.ser_valid = 1'b0;
        sif.align     = 1'b0;

        // Reset state
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_data_par", {30'd0, sif.data_par}, 0);
        check("rst_par_valid", {31'd0, sif.par_valid}, 0);
        check("rst_locked", {31'd0, sif.locked}, SYNC_ON ? 0 : 1);
        chk_en = 1'b1;

        // Basic stream
        lock_up();
        send('{1,0,1,0,1,1,0,1,1,0,0,0,1,1});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        expect_rel("stream", '{2,2,3,1,2,0,3});

        // Idle gaps hold the partial bit
        send('{1});
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        send('{0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        expect_rel("gap", '{2});

        // Align discards partial MSB and same-cycle bit
        send('{1});
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        lock_up();
        send('{0,1});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        expect_rel("align", '{1});

        // Reset mid-pair
        send('{1});
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_data_par", {30'd0, sif.data_par}, 0);
        check("midrst_par_valid", {31'd0, sif.par_valid}, 0);
        lock_up();
        send('{0,1});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        expect_rel("midrst", '{1});

        if (SYNC_ON) begin
            // Sync hunt: nothing before the match
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            send('{0,1,1,1,0,0,1,1,0});
            check("sync_pre_locked", {31'd0, sif.locked}, 0);
            send('{0});
            check("sync_locked", {31'd0, sif.locked}, 1);
            send('{1,1,0,1});
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            expect_rel("sync", '{3,1});

            // Loss of lock after GAP_MAX idle edges
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            lock_up();
            repeat (GAP_MAX - 1) cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check("gap_still_locked", {31'd0, sif.locked}, 1);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check("gap_lost", {31'd0, sif.locked}, 0);
            send('{1,0,1,1});
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            expect_rel("relock_none", '{});
            lock_up();
            send('{1,0});
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            expect_rel("relock", '{2});
        end else begin
            // Long idle never drops lock without the hunter
            send('{1});
            repeat (GAP_MAX + 4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check("nosync_locked", {31'd0, sif.locked}, 1);
            send('{0});
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            expect_rel("long_gap", '{2});
        end

        // Randomized traffic in bursts of differing density
        p = 90;
        for (int n = 0; n < 4000; n++) begin
            if (n % 50 == 0) begin
                case ($urandom_range(2))
                    0: p = 95;
                    1: p = 50;
                    default: p = 5;
                endcase
                if ($urandom_range(3) == 0) lock_up();
            end
            cyc(($urandom_range(199) != 0),
                ($urandom_range(99) < p),
                1'($urandom),
                ($urandom_range(99) == 0));
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
